// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable width/parity feeding a show-ahead receive FIFO.
// Sticky frame, parity and overflow flags are cleared by err_clr; a set in the same cycle wins.
module uart_rx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic                               clk,
   input  logic                               nRst,
   input  logic                               rx_serial,
   input  logic                               rd_en,
   input  logic                               err_clr,
   output logic [DATA_BITS-1:0]               dout,
   output logic                               empty,
   output logic                               full,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
   output logic                               frame_err,
   output logic                               parity_err,
   output logic                               overflow
);

   localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W  = $clog2(DATA_BITS);
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNTF_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
   localparam logic [CNTF_W-1:0] CNT_FULL  = CNTF_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK
   } state_e;

   logic                 sync1_q, sync2_q, rxs;
   state_e               state_q, state_d;
   logic [CNT_W-1:0]     tick_q, tick_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 push_q, push_d;
   logic [DATA_BITS-1:0] word_q, word_d;
   logic                 frame_err_q, frame_err_d;
   logic                 parity_err_q, parity_err_d;
   logic                 overflow_q, overflow_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CNTF_W-1:0]    cnt_q, cnt_d;
   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

   logic frame_set, parity_set, parity_ok, pop, wr, ovf_set;

   assign rxs       = sync2_q;
   assign parity_ok = (PARITY == 0) || ((^shift_q ^ par_q) == (PARITY == 2));

   // Receiver next-state: mid-bit sampling driven by the bit-tick counter
   always_comb begin
      state_d    = state_q;
      tick_d     = tick_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      par_d      = par_q;
      push_d     = 1'b0;
      word_d     = word_q;
      frame_set  = 1'b0;
      parity_set = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rxs) begin
               state_d = S_START;
               tick_d  = '0;
            end
         end
         S_START: begin
            if (tick_q == HALF_LAST) begin
               tick_d  = '0;
               idx_d   = '0;
               state_d = rxs ? S_IDLE : S_DATA;
            end else begin
               tick_d = tick_q + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (tick_q == BIT_LAST) begin
               tick_d  = '0;
               shift_d = {rxs, shift_q[DATA_BITS-1:1]};
               if (idx_q == IDX_LAST) begin
                  state_d = (PARITY != 0) ? S_PAR : S_STOP;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               tick_d = tick_q + CNT_W'(1);
            end
         end
         S_PAR: begin
            if (tick_q == BIT_LAST) begin
               tick_d  = '0;
               par_d   = rxs;
               state_d = S_STOP;
            end else begin
               tick_d = tick_q + CNT_W'(1);
            end
         end
         S_STOP: begin
            if (tick_q == BIT_LAST) begin
               tick_d = '0;
               if (!rxs) begin
                  frame_set = 1'b1;
                  state_d   = S_BREAK;
               end else if (parity_ok) begin
                  push_d  = 1'b1;
                  word_d  = shift_q;
                  state_d = S_IDLE;
               end else begin
                  parity_set = 1'b1;
                  state_d    = S_IDLE;
               end
            end else begin
               tick_d = tick_q + CNT_W'(1);
            end
         end
         S_BREAK: begin
            if (rxs) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FIFO bookkeeping: a pop frees the slot, so push+pop at full is accepted
   always_comb begin
      pop      = rd_en && (cnt_q != '0);
      wr       = push_q && ((cnt_q != CNT_FULL) || pop);
      ovf_set  = push_q && (cnt_q == CNT_FULL) && !rd_en;
      rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      wr_ptr_d = wr  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      cnt_d    = cnt_q;
      if (wr && !pop)      cnt_d = cnt_q + CNTF_W'(1);
      else if (pop && !wr) cnt_d = cnt_q - CNTF_W'(1);
      frame_err_d  = frame_set  | (frame_err_q  & ~err_clr);
      parity_err_d = parity_set | (parity_err_q & ~err_clr);
      overflow_d   = ovf_set    | (overflow_q   & ~err_clr);
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         state_q      <= S_IDLE;
         tick_q       <= '0;
         idx_q        <= '0;
         shift_q      <= '0;
         par_q        <= 1'b0;
         push_q       <= 1'b0;
         word_q       <= '0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overflow_q   <= 1'b0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         cnt_q        <= '0;
      end else begin
         sync1_q      <= rx_serial;
         sync2_q      <= sync1_q;
         state_q      <= state_d;
         tick_q       <= tick_d;
         idx_q        <= idx_d;
         shift_q      <= shift_d;
         par_q        <= par_d;
         push_q       <= push_d;
         word_q       <= word_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         overflow_q   <= overflow_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         cnt_q        <= cnt_d;
      end
   end

   // Storage needs no reset: count gates dout
   always_ff @(posedge clk) begin
      if (wr) mem_q[wr_ptr_q] <= word_q;
   end

   assign dout       = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign empty      = (cnt_q == '0);
   assign full       = (cnt_q == CNT_FULL);
   assign count      = cnt_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: one no-parity and one even-parity instance, 16 clocks per bit.
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       nRst;
   logic       rx0, rx1, rd0, rd1, clr0, clr1;
   logic [7:0] dout0, dout1;
   logic       empty0, empty1, full0, full1;
   logic [2:0] count0, count1;
   logic       ferr0, ferr1, perr0, perr1, ovf0, ovf1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_rx_fifo #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) u_dut0 (
      .clk(clk), .nRst(nRst), .rx_serial(rx0), .rd_en(rd0), .err_clr(clr0),
      .dout(dout0), .empty(empty0), .full(full0), .count(count0),
      .frame_err(ferr0), .parity_err(perr0), .overflow(ovf0));

   uart_rx_fifo #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(1), .FIFO_DEPTH(4)) u_dut1 (
      .clk(clk), .nRst(nRst), .rx_serial(rx1), .rd_en(rd1), .err_clr(clr1),
      .dout(dout1), .empty(empty1), .full(full1), .count(count1),
      .frame_err(ferr1), .parity_err(perr1), .overflow(ovf1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic b);
      if (sel) rx1 = b;
      else     rx0 = b;
   endtask

   // One frame; pop_at >= 0 pulses rd0 that many cycles into the stop bit
   task automatic send(input bit sel, input logic [7:0] d, input logic pbit,
                       input logic stop, input int pop_at);
      drive(sel, 1'b0);
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         drive(sel, d[i]);
         repeat (16) @(negedge clk);
      end
      if (sel) begin
         drive(sel, pbit);
         repeat (16) @(negedge clk);
      end
      drive(sel, stop);
      for (int c = 0; c < 16; c++) begin
         if (c == pop_at) rd0 = 1'b1;
         @(negedge clk);
         rd0 = 1'b0;
      end
      drive(sel, 1'b1);
   endtask

   task automatic pop0();
      rd0 = 1'b1;
      @(negedge clk);
      rd0 = 1'b0;
   endtask

   task automatic clear(input bit sel);
      if (sel) clr1 = 1'b1; else clr0 = 1'b1;
      @(negedge clk);
      clr0 = 1'b0;
      clr1 = 1'b0;
   endtask

   initial begin
      nRst = 1'b0; rx0 = 1'b1; rx1 = 1'b1;
      rd0 = 1'b0; rd1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_empty", 32'(empty0), 32'd1);
      chk("rst_full",  32'(full0),  32'd0);
      chk("rst_count", 32'(count0), 32'd0);
      chk("rst_dout",  32'(dout0),  32'd0);
      chk("rst_flags", 32'({ferr0, perr0, ovf0}), 32'd0);
      chk("rst_empty1", 32'(empty1), 32'd1);
      nRst = 1'b1;
      repeat (4) @(negedge clk);

      // single frame
      send(1'b0, 8'hA5, 1'b0, 1'b1, -1);
      chk("a5_empty", 32'(empty0), 32'd0);
      chk("a5_dout",  32'(dout0),  32'hA5);
      chk("a5_count", 32'(count0), 32'd1);
      chk("a5_flags", 32'({ferr0, perr0, ovf0}), 32'd0);
      pop0();
      chk("a5_pop_empty", 32'(empty0), 32'd1);
      chk("a5_pop_dout",  32'(dout0),  32'd0);

      // overflow and pointer wrap
      for (int w = 1; w <= 4; w++) send(1'b0, 8'(w), 1'b0, 1'b1, -1);
      chk("fill_full",  32'(full0),  32'd1);
      chk("fill_count", 32'(count0), 32'd4);
      chk("fill_ovf",   32'(ovf0),   32'd0);
      send(1'b0, 8'h05, 1'b0, 1'b1, -1);
      chk("ovf_flag",  32'(ovf0),   32'd1);
      chk("ovf_count", 32'(count0), 32'd4);
      for (int w = 1; w <= 4; w++) begin
         chk("drain_dout", 32'(dout0), 32'(w));
         pop0();
      end
      chk("drain_empty", 32'(empty0), 32'd1);
      send(1'b0, 8'h06, 1'b0, 1'b1, -1);
      send(1'b0, 8'h07, 1'b0, 1'b1, -1);
      chk("wrap_count", 32'(count0), 32'd2);
      chk("wrap_dout6", 32'(dout0),  32'h06);
      pop0();
      chk("wrap_dout7", 32'(dout0),  32'h07);
      pop0();
      chk("wrap_empty", 32'(empty0), 32'd1);
      chk("ovf_sticky", 32'(ovf0),   32'd1);
      clear(1'b0);
      chk("ovf_clr",    32'(ovf0),   32'd0);

      // push and pop in the same cycle while full
      for (int w = 0; w < 4; w++) send(1'b0, 8'(8'h10 + w), 1'b0, 1'b1, -1);
      chk("pp_full", 32'(full0), 32'd1);
      send(1'b0, 8'h14, 1'b0, 1'b1, 11);
      chk("pp_count", 32'(count0), 32'd4);
      chk("pp_ovf",   32'(ovf0),   32'd0);
      for (int w = 1; w <= 4; w++) begin
         chk("pp_dout", 32'(dout0), 32'(8'h10 + w));
         pop0();
      end
      chk("pp_empty", 32'(empty0), 32'd1);

      // framing error and held-low break
      send(1'b0, 8'h55, 1'b0, 1'b0, -1);
      chk("fe_flag",  32'(ferr0),  32'd1);
      chk("fe_empty", 32'(empty0), 32'd1);
      clear(1'b0);
      chk("fe_clr", 32'(ferr0), 32'd0);
      rx0 = 1'b0;
      repeat (320) @(negedge clk);
      chk("brk_first", 32'(ferr0), 32'd1);
      clear(1'b0);
      repeat (320) @(negedge clk);
      chk("brk_once",  32'(ferr0),  32'd0);
      chk("brk_empty", 32'(empty0), 32'd1);
      rx0 = 1'b1;
      repeat (32) @(negedge clk);
      chk("brk_rel", 32'(ferr0), 32'd0);
      send(1'b0, 8'h33, 1'b0, 1'b1, -1);
      chk("brk_next_dout",  32'(dout0),  32'h33);
      chk("brk_next_count", 32'(count0), 32'd1);
      pop0();

      // even parity on the second instance
      send(1'b1, 8'h03, 1'b0, 1'b1, -1);
      chk("par_ok_count", 32'(count1), 32'd1);
      chk("par_ok_dout",  32'(dout1),  32'h03);
      chk("par_ok_flag",  32'(perr1),  32'd0);
      send(1'b1, 8'h03, 1'b1, 1'b1, -1);
      chk("par_bad_flag",  32'(perr1),  32'd1);
      chk("par_bad_count", 32'(count1), 32'd1);
      clear(1'b1);
      chk("par_clr", 32'(perr1), 32'd0);
      send(1'b1, 8'h03, 1'b1, 1'b0, -1);
      chk("par_fe_frame",  32'(ferr1), 32'd1);
      chk("par_fe_parity", 32'(perr1), 32'd0);
      chk("par_fe_count",  32'(count1), 32'd1);

      // glitch rejection
      rx0 = 1'b0;
      repeat (3) @(negedge clk);
      rx0 = 1'b1;
      repeat (200) @(negedge clk);
      chk("glitch_empty", 32'(empty0), 32'd1);
      chk("glitch_flags", 32'({ferr0, perr0, ovf0}), 32'd0);

      // reset mid-frame with a word held
      send(1'b0, 8'h77, 1'b0, 1'b1, -1);
      chk("pre_rst_count", 32'(count0), 32'd1);
      rx0 = 1'b0;
      repeat (60) @(negedge clk);
      nRst = 1'b0;
      repeat (2) @(negedge clk);
      chk("mrst_count", 32'(count0), 32'd0);
      chk("mrst_dout",  32'(dout0),  32'd0);
      rx0  = 1'b1;
      nRst = 1'b1;
      repeat (4) @(negedge clk);
      chk("mrst_empty", 32'(empty0), 32'd1);
      chk("mrst_full",  32'(full0),  32'd0);
      chk("mrst_flags1", 32'({ferr1, perr1, ovf1, empty1}), 32'd1);
      send(1'b0, 8'h5A, 1'b0, 1'b1, -1);
      chk("post_rst_dout",  32'(dout0),  32'h5A);
      chk("post_rst_count", 32'(count0), 32'd1);
      chk("post_rst_flags", 32'({ferr0, perr0, ovf0}), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
